// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU host sequencer: FSM state encoding,
// opcode values and the default WAIT-cycle timeout.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_LOAD_Y = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/alu_host_sequencer_if.sv
// Request/response handshake and ALU drive/return bus of the host sequencer.
// master = sequencer side, slave = fabric + ALU side.
interface alu_host_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_x;
  logic [7:0]  req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_ovf;
  logic        rsp_err;
  logic        alu_start;
  logic [1:0]  alu_s;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_overflow;
  logic        alu_finish;

  modport master (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    input  alu_outbus, alu_overflow, alu_finish,
    output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err,
    output alu_start, alu_s, alu_inbus
  );

  modport slave (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    output alu_outbus, alu_overflow, alu_finish,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err,
    input  alu_start, alu_s, alu_inbus
  );
endinterface

// File: rtl/alu_seq_watchdog.sv
// Saturating cycle counter with clear and enable; expired flags the MAX-th
// enabled cycle so the caller can act in that same cycle.
module alu_seq_watchdog #(
  parameter int MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/alu_host_sequencer.sv
// Drives the sequential ALU (start/s/inbus) for one request at a time and returns
// the two result bytes with sticky overflow. Optional abort via ALU_SEQ_TIMEOUT_EN.
module alu_host_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_b,
  alu_host_sequencer_if.master  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  prev_q, prev_d;
  logic        ovf_q, ovf_d;
  logic [15:0] data_q, data_d;
  logic        rovf_q, rovf_d;
  logic        timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  alu_seq_watchdog #(
    .MAX (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst_b),
    .clr     (state_q == ST_START),
    .en      (state_q == ST_WAIT),
    .expired (timeout)
  );

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    x_d           = x_q;
    y_d           = y_q;
    prev_d        = prev_q;
    ovf_d         = ovf_q;
    data_d        = data_q;
    rovf_d        = rovf_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    err_d         = err_q;
`endif
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.alu_start = 1'b0;
    bus.alu_s     = 2'b00;
    bus.alu_inbus = 8'h00;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          x_d     = bus.req_x;
          y_d     = bus.req_y;
          prev_d  = 8'h00;
          ovf_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        bus.alu_start = 1'b1;
        bus.alu_s     = op_q;
        state_d       = ST_LOAD_X;
      end
      ST_LOAD_X: begin
        bus.alu_s     = op_q;
        bus.alu_inbus = x_q;
        state_d       = ST_LOAD_Y;
      end
      ST_LOAD_Y: begin
        bus.alu_s     = op_q;
        bus.alu_inbus = y_q;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        bus.alu_s = op_q;
        prev_d    = bus.alu_outbus;
        ovf_d     = ovf_q | bus.alu_overflow;
        // Finish takes priority over a timeout landing in the same cycle.
        if (bus.alu_finish) begin
          data_d  = {prev_q, bus.alu_outbus};
          rovf_d  = ovf_q | bus.alu_overflow;
`ifdef ALU_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end else if (timeout) begin
          data_d  = 16'h0000;
          rovf_d  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
          err_d   = 1'b1;
`endif
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      prev_q  <= 8'h00;
      ovf_q   <= 1'b0;
      data_q  <= 16'h0000;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      rovf_q  <= rovf_d;
    end
  end

  assign bus.rsp_data = data_q;
  assign bus.rsp_ovf  = rovf_q;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Bench for alu_host_sequencer: directed test-plan scenarios plus randomized ops,
// with an ALU stand-in whose result is the last two bytes it shows during WAIT.
module tb_alu_host_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  // Per-WAIT-cycle bytes and overflow bits the ALU stand-in presents.
  logic [7:0] wb [0:31];
  logic       wo [0:31];

  alu_host_sequencer_if bus ();

  alu_host_sequencer #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_b (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish, got stuck want completion");
    $fatal(1);
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      wb[i] = 8'h00;
      wo[i] = 1'b0;
    end
  endtask

  task automatic noise();
    bus.alu_finish   = 1'($urandom);
    bus.alu_overflow = 1'($urandom);
    bus.alu_outbus   = 8'($urandom);
  endtask

  // Runs one request end to end; returns in the IDLE cycle after the handshake.
  task automatic run_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        input int n, input bit fin, input int hold, input bit busy_req,
                        input string tag);
    logic [15:0] exp_data;
    logic        exp_ovf;
    logic        exp_err;
    int          guard;
    exp_err  = !fin;
    exp_data = 16'h0000;
    exp_ovf  = 1'b0;
    if (fin) begin
      exp_data = {((n >= 2) ? wb[n-2] : 8'h00), wb[n-1]};
      for (int i = 0; i < n; i++) exp_ovf |= wo[i];
    end

    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    n_total++;
    if (guard >= 50) $display("FAIL %s ready_wait req_ready=%b want 1", tag, bus.req_ready);
    else n_pass++;

    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_x     = 8'($urandom);
    bus.req_y     = 8'($urandom);
    n_total++;
    if ({bus.alu_start, bus.alu_s, bus.alu_inbus, bus.req_ready} !== {1'b1, op, 8'h00, 1'b0})
      $display("FAIL %s start_cycle start/s/inbus/rdy=%b/%b/%h/%b want 1/%b/00/0",
               tag, bus.alu_start, bus.alu_s, bus.alu_inbus, bus.req_ready, op);
    else n_pass++;
    noise();
    @(posedge clk); #1;
    n_total++;
    if ({bus.alu_start, bus.alu_s, bus.alu_inbus} !== {1'b0, op, x})
      $display("FAIL %s load_x start/s/inbus=%b/%b/%h want 0/%b/%h",
               tag, bus.alu_start, bus.alu_s, bus.alu_inbus, op, x);
    else n_pass++;
    noise();
    @(posedge clk); #1;
    n_total++;
    if ({bus.alu_start, bus.alu_s, bus.alu_inbus} !== {1'b0, op, y})
      $display("FAIL %s load_y start/s/inbus=%b/%b/%h want 0/%b/%h",
               tag, bus.alu_start, bus.alu_s, bus.alu_inbus, op, y);
    else n_pass++;
    noise();
    @(posedge clk); #1;

    for (int i = 0; i < n; i++) begin
      bus.alu_outbus   = wb[i];
      bus.alu_overflow = wo[i];
      bus.alu_finish   = fin && (i == n - 1);
      bus.req_valid    = busy_req;
      n_total++;
      if ({bus.alu_start, bus.alu_s, bus.alu_inbus, bus.rsp_valid, bus.req_ready} !==
          {1'b0, op, 8'h00, 1'b0, 1'b0})
        $display("FAIL %s wait_cycle%0d start/s/inbus/vld/rdy=%b/%b/%h/%b/%b want 0/%b/00/0/0",
                 tag, i, bus.alu_start, bus.alu_s, bus.alu_inbus, bus.rsp_valid,
                 bus.req_ready, op);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.req_valid    = 1'b0;
    bus.alu_finish   = 1'b0;
    bus.alu_overflow = 1'b0;

    n_total++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_err} !==
        {1'b1, exp_data, exp_ovf, exp_err})
      $display("FAIL %s response vld/data/ovf/err=%b/%h/%b/%b want 1/%h/%b/%b",
               tag, bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_err,
               exp_data, exp_ovf, exp_err);
    else n_pass++;

    for (int h = 0; h < hold; h++) begin
      noise();
      @(posedge clk); #1;
      n_total++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_err} !==
          {1'b1, exp_data, exp_ovf, exp_err})
        $display("FAIL %s hold%0d vld/data/ovf/err=%b/%h/%b/%b want 1/%h/%b/%b",
                 tag, h, bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_err,
                 exp_data, exp_ovf, exp_err);
      else n_pass++;
    end
    bus.alu_finish   = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.rsp_ready    = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_total++;
    if ({bus.rsp_valid, bus.req_ready, bus.alu_start} !== 3'b010)
      $display("FAIL %s after_handshake vld/rdy/start=%b/%b/%b want 0/1/0",
               tag, bus.rsp_valid, bus.req_ready, bus.alu_start);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_ovf, bus.rsp_err} !== 4'b1000)
      $display("FAIL reset_flags rdy/vld/ovf/err=%b/%b/%b/%b want 1/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_ovf, bus.rsp_err);
    else n_pass++;
    n_total++;
    if (bus.rsp_data !== 16'h0000)
      $display("FAIL reset_data rsp_data=%h want 0000", bus.rsp_data);
    else n_pass++;
    n_total++;
    if ({bus.alu_start, bus.alu_s, bus.alu_inbus} !== 11'd0)
      $display("FAIL reset_alu start/s/inbus=%b/%b/%h want 0/00/00",
               bus.alu_start, bus.alu_s, bus.alu_inbus);
    else n_pass++;
  endtask

  task automatic test_add();
    clear_model();
    wb[0] = 8'h00; wb[1] = 8'h08;
    run_op(2'b00, 8'h05, 8'h03, 2, 1'b1, 0, 1'b0, "add");
  endtask

  task automatic test_overflow();
    clear_model();
    wb[0] = 8'h3C; wb[1] = 8'h00; wb[2] = 8'h80;
    wo[1] = 1'b1;
    run_op(2'b00, 8'h7F, 8'h01, 3, 1'b1, 0, 1'b0, "ovf");
  endtask

  task automatic test_mul();
    clear_model();
    for (int i = 0; i < 8; i++) wb[i] = 8'(i * 17 + 3);
    wb[8] = 8'h00; wb[9] = 8'h84;
    run_op(2'b10, 8'h0C, 8'h0B, 10, 1'b1, 3, 1'b0, "mul");
  endtask

  task automatic test_div();
    clear_model();
    wb[0] = 8'hAA; wb[1] = 8'h55; wb[2] = 8'h01; wb[3] = 8'h03;
    run_op(2'b11, 8'h07, 8'h16, 4, 1'b1, 1, 1'b1, "div");
  endtask

  task automatic test_first_cycle_finish();
    clear_model();
    wb[0] = 8'h5A;
    run_op(2'b01, 8'h10, 8'h01, 1, 1'b1, 0, 1'b0, "fin_first");
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_x     = 8'h21;
    bus.req_y     = 8'h43;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (bus.alu_inbus !== 8'h43)
      $display("FAIL rst_mid_load_y inbus=%h want 43", bus.alu_inbus);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({bus.alu_start, bus.alu_s, bus.alu_inbus, bus.req_ready, bus.rsp_valid} !==
        {1'b0, 2'b00, 8'h00, 1'b1, 1'b0})
      $display("FAIL rst_mid_outputs start/s/inbus/rdy/vld=%b/%b/%h/%b/%b want 0/00/00/1/0",
               bus.alu_start, bus.alu_s, bus.alu_inbus, bus.req_ready, bus.rsp_valid);
    else n_pass++;
    n_total++;
    if ({bus.rsp_data, bus.rsp_ovf, bus.rsp_err} !== 18'd0)
      $display("FAIL rst_mid_rsp data/ovf/err=%h/%b/%b want 0000/0/0",
               bus.rsp_data, bus.rsp_ovf, bus.rsp_err);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    wb[0] = 8'h12; wb[1] = 8'h34;
    run_op(2'b01, 8'h46, 8'h12, 2, 1'b1, 0, 1'b0, "after_rst");
  endtask

  task automatic test_timeout();
`ifdef ALU_SEQ_TIMEOUT_EN
    clear_model();
    for (int i = 0; i < TO; i++) begin
      wb[i] = 8'(8'hC0 + i);
      wo[i] = (i == 2);
    end
    run_op(2'b10, 8'hFF, 8'hFF, TO, 1'b0, 1, 1'b0, "timeout");
    run_op(2'b10, 8'h02, 8'h03, TO, 1'b1, 0, 1'b0, "finish_at_limit");
`endif
  endtask

  task automatic test_random();
    int          nmax;
    int          n;
    logic [1:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    nmax = (TO < 12) ? TO : 12;
    for (int k = 0; k < 25; k++) begin
      op = 2'($urandom);
      x  = 8'($urandom);
      y  = 8'($urandom);
      n  = $urandom_range(1, nmax);
      for (int i = 0; i < 32; i++) begin
        wb[i] = 8'($urandom);
        wo[i] = ($urandom_range(0, 3) == 0);
      end
      run_op(op, x, y, n, 1'b1, $urandom_range(0, 2), 1'($urandom), "random");
    end
  endtask

  initial begin
    n_pass           = 0;
    n_total          = 0;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_x        = 8'h00;
    bus.req_y        = 8'h00;
    bus.rsp_ready    = 1'b0;
    bus.alu_outbus   = 8'h00;
    bus.alu_overflow = 1'b0;
    bus.alu_finish   = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_add();
    test_overflow();
    test_mul();
    test_div();
    test_first_cycle_finish();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
